// File: rtl/pcode_pkg.sv
// Shared constants and FSM state encoding for the P-code chip scheduler.
package pcode_pkg;
  localparam int SAT_WIDTH   = 6;
  localparam int LEN_WIDTH   = 16;
  localparam int WORD_WIDTH  = 32;
  localparam int INIT_CYCLES = 2;
  localparam int PRIME_CHIPS = 2;
  localparam int SAT_MAX     = 37;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    PRIME = 3'd2,
    RUN   = 3'd3,
    DRAIN = 3'd4
  } state_t;
endpackage

// File: rtl/pcode_packer.sv
// Packs gated generator chips MSB-first into words and holds each word on a
// valid/ready output register; a completed word may replace one leaving the same edge.
module pcode_packer #(
  parameter int WORD_WIDTH = pcode_pkg::WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  chip_en,
  input  logic                  chip,
  input  logic                  last_in,
  input  logic                  out_ready,
  output logic                  stall,
  output logic                  load,
  output logic                  out_valid,
  output logic [WORD_WIDTH-1:0] out_data,
  output logic                  out_last
);
  localparam int CW = $clog2(WORD_WIDTH);

  logic [CW-1:0]         chip_cnt_r;
  logic [WORD_WIDTH-2:0] shift_r;
  logic [WORD_WIDTH-1:0] data_r;
  logic                  valid_r;
  logic                  last_r;
  logic                  at_top_s;
  logic [WORD_WIDTH-1:0] word_s;

  assign at_top_s = (chip_cnt_r == CW'(WORD_WIDTH - 1));
  assign word_s   = {shift_r, chip};
  // Only the final chip of a word can be blocked: the output slot must be free or leaving.
  assign stall    = at_top_s & valid_r & ~out_ready;
  assign load     = chip_en & at_top_s & ~flush;

  assign out_valid = valid_r;
  assign out_data  = data_r;
  assign out_last  = last_r;

  // Chip counter, shift register and output word register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chip_cnt_r <= '0;
      shift_r    <= '0;
      data_r     <= '0;
      valid_r    <= 1'b0;
      last_r     <= 1'b0;
    end else begin
      if (flush) begin
        chip_cnt_r <= '0;
      end else if (chip_en) begin
        chip_cnt_r <= at_top_s ? '0 : chip_cnt_r + CW'(1);
      end
      if (chip_en) begin
        shift_r <= word_s[WORD_WIDTH-2:0];
      end
      if (flush) begin
        valid_r <= 1'b0;
      end else if (load) begin
        valid_r <= 1'b1;
        data_r  <= word_s;
        last_r  <= last_in;
      end else if (out_ready) begin
        valid_r <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/pcode_sched.sv
// Job-level controller: validates a request, re-initialises and primes the
// P-code generator, then gates it chip by chip into the word packer.
module pcode_sched #(
  parameter int SAT_WIDTH   = pcode_pkg::SAT_WIDTH,
  parameter int LEN_WIDTH   = pcode_pkg::LEN_WIDTH,
  parameter int WORD_WIDTH  = pcode_pkg::WORD_WIDTH,
  parameter int INIT_CYCLES = pcode_pkg::INIT_CYCLES,
  parameter int PRIME_CHIPS = pcode_pkg::PRIME_CHIPS,
  parameter int SAT_MAX     = pcode_pkg::SAT_MAX
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [SAT_WIDTH-1:0]  req_sat,
  input  logic [LEN_WIDTH-1:0]  req_len,
  input  logic                  abort,
  output logic                  gen_rst,
  output logic                  gen_en,
  output logic [SAT_WIDTH-1:0]  gen_sat,
  input  logic                  gen_chip,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic                  err_sat
);
  import pcode_pkg::*;

  state_t               state_r;
  logic [7:0]           phase_r;
  logic [LEN_WIDTH-1:0] len_r;
  logic [LEN_WIDTH-1:0] word_cnt_r;
  logic [SAT_WIDTH-1:0] sat_r;
  logic                 err_r;
  logic                 done_r;

  logic sat_ok_s;
  logic kill_s;
  logic is_last_s;
  logic run_en_s;
  logic stall_s;
  logic load_s;

  assign sat_ok_s  = (req_sat != '0) && (req_sat <= SAT_WIDTH'(SAT_MAX));
  assign kill_s    = abort & (state_r != IDLE);
  // word_cnt_r counts words already loaded, so the loading word is last when it equals len-1.
  assign is_last_s = (word_cnt_r == len_r - LEN_WIDTH'(1));
  assign run_en_s  = (state_r == RUN) & ~stall_s;

  assign gen_en    = (state_r == PRIME) | run_en_s;
  assign gen_rst   = (state_r == INIT);
  assign req_ready = (state_r == IDLE);
  assign busy      = (state_r != IDLE);
  assign gen_sat   = sat_r;
  assign done      = done_r;
  assign err_sat   = err_r;

  pcode_packer #(.WORD_WIDTH(WORD_WIDTH)) u_packer (
    .clk       (clk),
    .rst       (rst),
    .flush     (kill_s),
    .chip_en   (run_en_s),
    .chip      (gen_chip),
    .last_in   (is_last_s),
    .out_ready (out_ready),
    .stall     (stall_s),
    .load      (load_s),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  // Job FSM with phase and word counters; abort overrides every other transition.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      phase_r    <= 8'd0;
      len_r      <= '0;
      word_cnt_r <= '0;
      sat_r      <= '0;
      err_r      <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (kill_s) begin
        state_r <= IDLE;
        done_r  <= 1'b1;
      end else begin
        case (state_r)
          IDLE: begin
            if (req_valid) begin
              if (!sat_ok_s) begin
                err_r  <= 1'b1;
                done_r <= 1'b1;
              end else begin
                err_r <= 1'b0;
                if (req_len == '0) begin
                  done_r <= 1'b1;
                end else begin
                  sat_r      <= req_sat;
                  len_r      <= req_len;
                  word_cnt_r <= '0;
                  phase_r    <= 8'd0;
                  state_r    <= INIT;
                end
              end
            end
          end
          INIT: begin
            if (phase_r == 8'(INIT_CYCLES - 1)) begin
              phase_r <= 8'd0;
              state_r <= PRIME;
            end else begin
              phase_r <= phase_r + 8'd1;
            end
          end
          PRIME: begin
            if (phase_r == 8'(PRIME_CHIPS - 1)) begin
              phase_r <= 8'd0;
              state_r <= RUN;
            end else begin
              phase_r <= phase_r + 8'd1;
            end
          end
          RUN: begin
            if (load_s) begin
              word_cnt_r <= word_cnt_r + LEN_WIDTH'(1);
              if (is_last_s) begin
                state_r <= DRAIN;
              end
            end
          end
          DRAIN: begin
            if (out_valid && out_ready) begin
              done_r  <= 1'b1;
              state_r <= IDLE;
            end
          end
          default: state_r <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_pcode_sched.sv
// Directed bench for pcode_sched with a behavioural generator (two-chip pipeline)
// and a golden chip sequence per PRN.
module tb_pcode_sched;
  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_sat;
  logic [15:0] req_len;
  logic        abort;
  logic        gen_rst;
  logic        gen_en;
  logic [5:0]  gen_sat;
  logic        gen_chip;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;
  logic        err_sat;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] wq[$];
  logic        lq[$];
  int          n_rst = 0;
  int          n_en = 0;
  int          n_done = 0;
  logic [31:0] gcnt = 32'd0;

  pcode_sched dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_sat(req_sat), .req_len(req_len), .abort(abort), .gen_rst(gen_rst),
    .gen_en(gen_en), .gen_sat(gen_sat), .gen_chip(gen_chip), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .busy(busy),
    .done(done), .err_sat(err_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic chip_at(input int sat, input int k);
    logic [31:0] h;
    h = (32'(k) + 32'd1) * 32'h9E3779B1 + 32'(sat) * 32'h7F4A7C15;
    h = h ^ (h >> 13);
    return h[5];
  endfunction

  function automatic logic [31:0] golden_word(input int sat, input int w);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[31-i] = chip_at(sat, w * 32 + i);
    return r;
  endfunction

  // generator model: chip k appears after k+2 enabled edges following gen_rst
  always @(posedge clk) begin
    if (gen_rst) gcnt = 32'd0;
    else if (gen_en) gcnt = gcnt + 32'd1;
  end
  assign gen_chip = (gcnt >= 32'd2) ? chip_at(int'(gen_sat), int'(gcnt - 32'd2)) : 1'b1;

  always @(posedge clk) begin
    if (rst && out_valid && out_ready) begin
      wq.push_back(out_data);
      lq.push_back(out_last);
    end
    if (gen_rst) n_rst = n_rst + 1;
    if (gen_en) n_en = n_en + 1;
    if (done) n_done = n_done + 1;
  end

  task automatic clear_mon();
    wq.delete();
    lq.delete();
    n_rst = 0;
    n_en = 0;
    n_done = 0;
  endtask

  task automatic issue(input int sat, input int len);
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL req_ready_before_issue: got %b want 1", req_ready);
    end
    req_sat = 6'(sat);
    req_len = 16'(len);
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_done_timeout: got done=%b want 1 within 400 cycles", name, done);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_words(input string name, input int sat, input int nw);
    logic [31:0] got;
    logic        gl;
    vectors++;
    if (wq.size() != nw) begin
      miscompares++;
      $display("FAIL %s_word_count: got %0d want %0d", name, wq.size(), nw);
    end
    for (int i = 0; i < nw; i++) begin
      got = (i < wq.size()) ? wq[i] : 32'hxxxxxxxx;
      gl  = (i < lq.size()) ? lq[i] : 1'bx;
      vectors++;
      if (got !== golden_word(sat, i) || gl !== (i == nw - 1)) begin
        miscompares++;
        $display("FAIL %s_word%0d: got %h last=%b want %h last=%b", name, i, got, gl,
                 golden_word(sat, i), (i == nw - 1));
      end
    end
  endtask

  task automatic test_reset();
    vectors++;
    if ({req_ready, busy, out_valid, out_last, gen_en, gen_rst, done, err_sat} !== 8'b1000_0000) begin
      miscompares++;
      $display("FAIL reset_flags: got %b want 10000000",
               {req_ready, busy, out_valid, out_last, gen_en, gen_rst, done, err_sat});
    end
    vectors++;
    if (gen_sat !== 6'd0 || out_data !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_data: got sat=%0d data=%h want 0 0", gen_sat, out_data);
    end
  endtask

  task automatic test_length();
    int n;
    clear_mon();
    out_ready = 1'b1;
    issue(5, 2);
    wait_valid(n);
    vectors++;
    if (n != 36) begin
      miscompares++;
      $display("FAIL length_latency: got %0d want 36", n);
    end
    wait_done("length");
    check_words("length", 5, 2);
    vectors++;
    if (n_done != 1 || n_rst != 2 || n_en != 66 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL length_counts: got done=%0d rst=%0d en=%0d busy=%b want 1 2 66 0",
               n_done, n_rst, n_en, busy);
    end
  endtask

  task automatic test_illegal();
    clear_mon();
    issue(0, 3);
    vectors++;
    if (err_sat !== 1'b1 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL illegal_sat0: got err=%b done=%b want 1 1", err_sat, done);
    end
    @(posedge clk); #1;
    issue(38, 3);
    vectors++;
    if (err_sat !== 1'b1 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL illegal_sat38: got err=%b done=%b want 1 1", err_sat, done);
    end
    repeat (5) @(posedge clk);
    #1;
    vectors++;
    if (n_rst != 0 || n_en != 0 || wq.size() != 0 || busy !== 1'b0 || err_sat !== 1'b1) begin
      miscompares++;
      $display("FAIL illegal_quiet: got rst=%0d en=%0d words=%0d busy=%b err=%b want 0 0 0 0 1",
               n_rst, n_en, wq.size(), busy, err_sat);
    end
    clear_mon();
    issue(1, 1);
    vectors++;
    if (err_sat !== 1'b0) begin
      miscompares++;
      $display("FAIL illegal_clear: got err=%b want 0", err_sat);
    end
    wait_done("legal1");
    check_words("legal1", 1, 1);
  endtask

  task automatic test_backpressure();
    int n;
    int en_cnt = 0;
    clear_mon();
    out_ready = 1'b0;
    issue(12, 4);
    wait_valid(n);
    for (int i = 0; i < 40; i++) begin
      if (gen_en) en_cnt++;
      @(posedge clk); #1;
    end
    vectors++;
    if (en_cnt != 31 || gen_en !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_stall_gen_en: got en_cycles=%0d gen_en=%b want 31 0", en_cnt, gen_en);
    end
    vectors++;
    if (out_valid !== 1'b1 || out_data !== golden_word(12, 0)) begin
      miscompares++;
      $display("FAIL bp_hold: got valid=%b data=%h want 1 %h", out_valid, out_data, golden_word(12, 0));
    end
    out_ready = 1'b1;
    wait_done("bp");
    check_words("bp", 12, 4);
  endtask

  task automatic test_abort();
    int n;
    clear_mon();
    out_ready = 1'b0;
    issue(5, 3);
    wait_valid(n);
    repeat (17) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    vectors++;
    if ({gen_en, out_valid, done, busy, req_ready} !== 5'b00101) begin
      miscompares++;
      $display("FAIL abort_state: got en,valid,done,busy,ready=%b want 00101",
               {gen_en, out_valid, done, busy, req_ready});
    end
    @(posedge clk); #1;
    vectors++;
    if (done !== 1'b0 || wq.size() != 0) begin
      miscompares++;
      $display("FAIL abort_after: got done=%b words=%0d want 0 0", done, wq.size());
    end
    clear_mon();
    out_ready = 1'b1;
    issue(5, 1);
    wait_done("abort_fresh");
    check_words("abort_fresh", 5, 1);
  endtask

  task automatic test_reset_midrun();
    int n;
    int spurious = 0;
    clear_mon();
    out_ready = 1'b0;
    issue(7, 2);
    wait_valid(n);
    #3;
    rst = 1'b0;
    #1;
    vectors++;
    if ({req_ready, busy, out_valid, out_last, gen_en, gen_rst, done} !== 7'b1000000 ||
        gen_sat !== 6'd0 || out_data !== 32'd0) begin
      miscompares++;
      $display("FAIL midrun_reset: got flags=%b sat=%0d data=%h want 1000000 0 0",
               {req_ready, busy, out_valid, out_last, gen_en, gen_rst, done}, gen_sat, out_data);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (out_valid || gen_en || busy) spurious++;
      @(posedge clk); #1;
    end
    vectors++;
    if (spurious != 0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL midrun_after: got spurious=%0d ready=%b want 0 1", spurious, req_ready);
    end
  endtask

  task automatic test_zero_len();
    clear_mon();
    issue(9, 0);
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_done: got done=%b busy=%b want 1 0", done, busy);
    end
    repeat (4) @(posedge clk);
    #1;
    vectors++;
    if (done !== 1'b0 || n_rst != 0 || n_done != 1 || wq.size() != 0) begin
      miscompares++;
      $display("FAIL zero_quiet: got done=%b rst=%0d pulses=%0d words=%0d want 0 0 1 0",
               done, n_rst, n_done, wq.size());
    end
  endtask

  initial begin
    rst = 1'b0;
    req_valid = 1'b0;
    req_sat = 6'd0;
    req_len = 16'd0;
    abort = 1'b0;
    out_ready = 1'b0;
    #2;
    test_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    test_length();
    test_illegal();
    test_backpressure();
    test_abort();
    test_reset_midrun();
    test_zero_len();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
